leitor_fila_pedidos: RTL and testbench
======================================

// Module: leitor_fila_pedidos
// PURPOSE
//  Read-side consumer of the 16-entry request queue RAM (sync_ram_16x4_mod). Watches the head entry
//  (addr 0), presents it as the next stop to the motion controller over a valid/ready handshake and,
//  once the stop is accepted, pops the head with a one-cycle shift pulse. Tracks queue occupancy from
//  writer push strobes and its own pops. Also issues queue clear on flush.
// PARAMETERS
//  DEPTH   16  queue entries; occupancy saturates here
//  CNT_W   5   occupancy width; must hold DEPTH
//  RD_LAT  1   cycles from addr/shift change until RAM head outputs are valid (>=1)
// PORTS
//  clk             in   1      rising-edge clock
//  reset           in   1      synchronous, active-high reset
//  push            in   1      writer did weT or fit this cycle (one pulse per stored entry)
//  flush           in   1      request full queue clear
//  ram_eh_origem   in   1      head entry: 1 = origin leg, 0 = destination leg
//  ram_tipo        in   2      head entry object type
//  ram_origem      in   2      head entry origin floor
//  ram_destino     in   2      head entry destination floor
//  andar_atual     in   2      current floor (used only with LEITOR_SKIP_SAME_FLOOR_EN)
//  ram_addr        out  4      read address to RAM; constant 0 (head)
//  ram_shift       out  1      one-cycle pop pulse to RAM shift
//  ram_clear       out  1      one-cycle pulse to RAM clear
//  stop_valid      out  1      stop_* fields hold a pending stop
//  stop_ready      in   1      motion controller accepts stop
//  stop_andar      out  2      target floor: ram_origem if eh_origem else ram_destino
//  stop_eh_origem  out  1      latched eh_origem
//  stop_tipo       out  2      latched tipo
//  occupancy       out  CNT_W  entries in queue
//  empty / full    out  1      occupancy==0 / occupancy==DEPTH
//  overflow        out  1      sticky: push seen while full
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0 (ram_addr 0, stop_* 0, occupancy 0, empty 1, overflow 0).
//  - FSM: IDLE -> FETCH when occupancy!=0. FETCH holds RD_LAT cycles, then latches head fields into
//    stop_* and goes to OFFER. OFFER: stop_valid=1, stop_* stable until stop_valid&&stop_ready.
//    Handshake cycle -> POP: ram_shift=1 for exactly one cycle, stop_valid=0, occupancy-1.
//    POP -> FETCH if occupancy after pop !=0, else IDLE.
//  - Latency: push at edge N into empty queue -> occupancy 1 after N, FETCH after N+1,
//    stop_valid high after N+1+RD_LAT. Back-to-back entries: ready at edge M -> shift pulse
//    in cycle M..M+1, next stop_valid at M+1+RD_LAT.
//  - stop_valid never drops without handshake except on flush/reset. stop_ready ignored when !valid.
//  - Occupancy: push and pop in same cycle -> unchanged. Push while full -> occupancy stays DEPTH,
//    overflow set (cleared only by reset). Pop never occurs at occupancy 0.
//  - Flush (any state, incl. mid-OFFER or POP): next cycle ram_clear=1 for one cycle, stop_valid=0,
//    occupancy=0, state IDLE; a push in the flush cycle is discarded. overflow is not cleared.
//  - Reset wins over flush, push and handshake in the same cycle.
// CONFIGURATION
//  LEITOR_SKIP_SAME_FLOOR_EN defined: at end of FETCH, if the computed target floor equals
//  andar_atual, the entry is not offered; go straight to POP (shift pulse, occupancy-1) with
//  stop_valid held 0. Not defined: andar_atual ignored; every entry is offered.
// TESTING
//  1 reset; push x1, head {eo=1,tipo=10,orig=10,dest=01} -> occupancy=1, stop_valid after 2 cycles,
//    stop_andar=10, stop_tipo=10; ready=1 -> ram_shift one pulse, occupancy=0, IDLE, empty=1.
//  2 stop_ready held 0 for 10 cycles with head data changing -> stop_* stay at latched values,
//    stop_valid stays 1, no ram_shift.
//  3 17 push pulses, no ready -> occupancy=16, full=1, overflow=1; then 16 handshakes -> 16 shift
//    pulses, occupancy=0.
//  4 push coincident with handshake at occupancy=3 -> occupancy stays 3; one shift pulse.
//  5 flush during OFFER at occupancy=5 -> ram_clear one pulse, stop_valid=0, occupancy=0, no shift.
//  6 macro on: andar_atual=01, head eo=0 dest=01 -> shift pulse with stop_valid never 1;
//    macro off: same stimulus -> offered with stop_andar=01.

Source files
------------

// File: rtl/leitor_fila_pedidos.sv
// leitor_fila_pedidos: read-side consumer of the 16-entry request queue RAM.
// Watches the head entry (addr 0) and offers it to the motion controller over
// a valid/ready handshake. After the stop is accepted it pops the head with a
// one-cycle shift pulse. It tracks occupancy from writer push strobes and its
// own pops, and issues a one-cycle queue clear on flush.
//
// Optional feature (macro LEITOR_SKIP_SAME_FLOOR_EN): entries whose target
// floor equals andar_atual are popped without being offered.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   push              writer stored one entry this cycle
//   flush             request full queue clear
//   ram_eh_origem, ram_tipo, ram_origem, ram_destino
//                     head entry fields from the RAM
//   andar_atual       current floor (only used with the optional feature)
//   ram_addr          read address to the RAM, always 0 (head)
//   ram_shift         one-cycle pop pulse to the RAM
//   ram_clear         one-cycle clear pulse to the RAM
//   stop_valid, stop_ready
//                     handshake with the motion controller
//   stop_andar, stop_eh_origem, stop_tipo
//                     latched stop fields
//   occupancy         entries currently in the queue
//   empty, full       occupancy == 0 and occupancy == DEPTH
//   overflow          sticky flag: a push arrived while the queue was full
module leitor_fila_pedidos #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CNT_W  = 5,
  parameter int unsigned RD_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             flush,
  input  logic             ram_eh_origem,
  input  logic [1:0]       ram_tipo,
  input  logic [1:0]       ram_origem,
  input  logic [1:0]       ram_destino,
  input  logic [1:0]       andar_atual,
  output logic [3:0]       ram_addr,
  output logic             ram_shift,
  output logic             ram_clear,
  output logic             stop_valid,
  input  logic             stop_ready,
  output logic [1:0]       stop_andar,
  output logic             stop_eh_origem,
  output logic [1:0]       stop_tipo,
  output logic [CNT_W-1:0] occupancy,
  output logic             empty,
  output logic             full,
  output logic             overflow
);

  localparam int unsigned LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    OFFER = 2'd2,
    POP   = 2'd3
  } state_t;

  state_t           state;
  logic [LAT_W-1:0] lat_cnt;

  logic [1:0]       head_andar_c;
  logic             fetch_done_c;
  logic             skip_c;
  logic             pop_c;
  logic             at_full_c;
  logic [CNT_W-1:0] occ_nxt_c;

  // The queue is always read at its head.
  assign ram_addr = 4'd0;

  // Target floor, pop decision and next occupancy.
  always_comb begin
    head_andar_c = ram_eh_origem ? ram_origem : ram_destino;
    fetch_done_c = (state == FETCH) && (lat_cnt == LAT_W'(RD_LAT - 1));
`ifdef LEITOR_SKIP_SAME_FLOOR_EN
    skip_c       = fetch_done_c && (head_andar_c == andar_atual);
`else
    skip_c       = 1'b0;
`endif
    pop_c        = skip_c || ((state == OFFER) && stop_valid && stop_ready);
    at_full_c    = (occupancy == CNT_W'(DEPTH));
    occ_nxt_c    = occupancy;
    if (push && !pop_c) begin
      if (!at_full_c) occ_nxt_c = occupancy + CNT_W'(1);
    end else if (!push && pop_c) begin
      occ_nxt_c = occupancy - CNT_W'(1);
    end
  end

`ifndef LEITOR_SKIP_SAME_FLOOR_EN
  // andar_atual has no function when same-floor skipping is disabled.
  logic unused_andar;
  assign unused_andar = ^andar_atual;
`endif

  // Controller FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      lat_cnt        <= '0;
      ram_shift      <= 1'b0;
      ram_clear      <= 1'b0;
      stop_valid     <= 1'b0;
      stop_andar     <= 2'd0;
      stop_eh_origem <= 1'b0;
      stop_tipo      <= 2'd0;
      occupancy      <= '0;
      empty          <= 1'b1;
      full           <= 1'b0;
      overflow       <= 1'b0;
    end else if (flush) begin
      // A flush overrides any push or handshake in the same cycle.
      state      <= IDLE;
      lat_cnt    <= '0;
      ram_shift  <= 1'b0;
      ram_clear  <= 1'b1;
      stop_valid <= 1'b0;
      occupancy  <= '0;
      empty      <= 1'b1;
      full       <= 1'b0;
    end else begin
      ram_shift <= 1'b0;
      ram_clear <= 1'b0;
      occupancy <= occ_nxt_c;
      empty     <= (occ_nxt_c == '0);
      full      <= (occ_nxt_c == CNT_W'(DEPTH));
      // A push that coincides with a pop is absorbed, so it is not an overflow.
      if (push && !pop_c && at_full_c) overflow <= 1'b1;

      case (state)
        IDLE: begin
          if (occupancy != '0) begin
            state   <= FETCH;
            lat_cnt <= '0;
          end
        end
        FETCH: begin
          if (skip_c) begin
            state     <= POP;
            ram_shift <= 1'b1;
          end else if (fetch_done_c) begin
            stop_andar     <= head_andar_c;
            stop_eh_origem <= ram_eh_origem;
            stop_tipo      <= ram_tipo;
            stop_valid     <= 1'b1;
            state          <= OFFER;
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        OFFER: begin
          if (pop_c) begin
            stop_valid <= 1'b0;
            ram_shift  <= 1'b1;
            state      <= POP;
          end
        end
        POP: begin
          // occupancy already reflects the pop made on entry to POP.
          if (occupancy != '0) begin
            state   <= FETCH;
            lat_cnt <= '0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_leitor_fila_pedidos.sv
// Directed testbench for leitor_fila_pedidos. The bench drives the RAM head
// fields directly and checks against hand-computed values.
module tb_leitor_fila_pedidos;

  logic       clk = 1'b0;
  logic       reset, push, flush, ram_eh_origem, stop_ready;
  logic [1:0] ram_tipo, ram_origem, ram_destino, andar_atual;
  logic [3:0] ram_addr;
  logic       ram_shift, ram_clear, stop_valid, stop_eh_origem;
  logic [1:0] stop_andar, stop_tipo;
  logic [4:0] occupancy;
  logic       empty, full, overflow;

  int n_checks = 0;
  int n_pass   = 0;
  int shift_cnt = 0;
  int clear_cnt = 0;
  int valid_cnt = 0;
  int s0, c0, v0;

  leitor_fila_pedidos dut (
    .clk(clk), .reset(reset), .push(push), .flush(flush),
    .ram_eh_origem(ram_eh_origem), .ram_tipo(ram_tipo),
    .ram_origem(ram_origem), .ram_destino(ram_destino),
    .andar_atual(andar_atual), .ram_addr(ram_addr),
    .ram_shift(ram_shift), .ram_clear(ram_clear),
    .stop_valid(stop_valid), .stop_ready(stop_ready),
    .stop_andar(stop_andar), .stop_eh_origem(stop_eh_origem),
    .stop_tipo(stop_tipo), .occupancy(occupancy),
    .empty(empty), .full(full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Pulse and valid-cycle counters, each sampled at the clock edge.
  always @(posedge clk) begin
    if (ram_shift)  shift_cnt <= shift_cnt + 1;
    if (ram_clear)  clear_cnt <= clear_cnt + 1;
    if (stop_valid) valid_cnt <= valid_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_head(input logic eo, input logic [1:0] tp, input logic [1:0] org,
                          input logic [1:0] dst);
    ram_eh_origem = eo;
    ram_tipo      = tp;
    ram_origem    = org;
    ram_destino   = dst;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; flush = 1'b0; stop_ready = 1'b0;
    andar_atual = 2'd0;
    set_head(1'b0, 2'd0, 2'd0, 2'd0);
    do_reset();

    // Reset state
    check("rst_valid", 32'(stop_valid), 0);
    check("rst_occ", 32'(occupancy), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_shift", 32'(ram_shift), 0);
    check("rst_clear", 32'(ram_clear), 0);
    check("rst_addr", 32'(ram_addr), 0);

    // 1: single entry, origin leg
    set_head(1'b1, 2'b10, 2'b10, 2'b01);
    push = 1'b1; step(); push = 1'b0;
    check("t1_occ", 32'(occupancy), 1);
    check("t1_empty", 32'(empty), 0);
    check("t1_valid_n", 32'(stop_valid), 0);
    step();
    check("t1_valid_n1", 32'(stop_valid), 0);
    step();
    check("t1_valid", 32'(stop_valid), 1);
    check("t1_andar", 32'(stop_andar), 2);
    check("t1_tipo", 32'(stop_tipo), 2);
    check("t1_eo", 32'(stop_eh_origem), 1);
    s0 = shift_cnt;
    stop_ready = 1'b1; step(); stop_ready = 1'b0;
    check("t1_shift", 32'(ram_shift), 1);
    check("t1_valid_hs", 32'(stop_valid), 0);
    check("t1_occ0", 32'(occupancy), 0);
    check("t1_empty1", 32'(empty), 1);
    step();
    check("t1_shift_end", 32'(ram_shift), 0);
    step(3);
    check("t1_npulse", 32'(shift_cnt - s0), 1);
    check("t1_idle_valid", 32'(stop_valid), 0);

    // 2: stop fields hold while not ready, head data changing
    set_head(1'b0, 2'b01, 2'b00, 2'b11);
    push = 1'b1; step(); push = 1'b0;
    step(2);
    check("t2_valid", 32'(stop_valid), 1);
    check("t2_andar", 32'(stop_andar), 3);
    s0 = shift_cnt;
    for (int i = 0; i < 10; i++) begin
      set_head(1'(i), 2'(i + 2), 2'(i), 2'(i + 1));
      step();
    end
    check("t2_hold_valid", 32'(stop_valid), 1);
    check("t2_hold_andar", 32'(stop_andar), 3);
    check("t2_hold_tipo", 32'(stop_tipo), 1);
    check("t2_hold_eo", 32'(stop_eh_origem), 0);
    check("t2_noshift", 32'(shift_cnt - s0), 0);
    stop_ready = 1'b1; step(); stop_ready = 1'b0;
    step(2);
    check("t2_drain", 32'(occupancy), 0);

    // 3: 17 pushes saturate at 16 and set overflow, then drain
    push = 1'b1; step(17); push = 1'b0;
    check("t3_occ", 32'(occupancy), 16);
    check("t3_full", 32'(full), 1);
    check("t3_ovf", 32'(overflow), 1);
    check("t3_valid", 32'(stop_valid), 1);
    s0 = shift_cnt;
    stop_ready = 1'b1; step(60); stop_ready = 1'b0;
    check("t3_pulses", 32'(shift_cnt - s0), 16);
    check("t3_occ0", 32'(occupancy), 0);
    check("t3_empty", 32'(empty), 1);
    check("t3_full0", 32'(full), 0);
    check("t3_ovf_sticky", 32'(overflow), 1);
    do_reset();
    check("t3_ovf_rst", 32'(overflow), 0);

    // 4: push together with handshake at occupancy 3
    push = 1'b1; step(3); push = 1'b0;
    check("t4_occ3", 32'(occupancy), 3);
    check("t4_valid", 32'(stop_valid), 1);
    s0 = shift_cnt;
    push = 1'b1; stop_ready = 1'b1; step(); push = 1'b0; stop_ready = 1'b0;
    check("t4_occ_same", 32'(occupancy), 3);
    check("t4_shift", 32'(ram_shift), 1);
    step(2);
    check("t4_npulse", 32'(shift_cnt - s0), 1);
    check("t4_occ_after", 32'(occupancy), 3);

    // 5: flush during OFFER at occupancy 5; push in the flush cycle is dropped
    push = 1'b1; step(2); push = 1'b0;
    check("t5_occ5", 32'(occupancy), 5);
    check("t5_valid", 32'(stop_valid), 1);
    s0 = shift_cnt; c0 = clear_cnt;
    flush = 1'b1; push = 1'b1; step(); flush = 1'b0; push = 1'b0;
    check("t5_clear", 32'(ram_clear), 1);
    check("t5_valid0", 32'(stop_valid), 0);
    check("t5_occ0", 32'(occupancy), 0);
    check("t5_empty", 32'(empty), 1);
    step();
    check("t5_clear_end", 32'(ram_clear), 0);
    step(3);
    check("t5_nclear", 32'(clear_cnt - c0), 1);
    check("t5_noshift", 32'(shift_cnt - s0), 0);
    check("t5_idle_valid", 32'(stop_valid), 0);
    check("t5_idle_occ", 32'(occupancy), 0);

    // 6: destination leg on the current floor
    andar_atual = 2'b01;
    set_head(1'b0, 2'b00, 2'b11, 2'b01);
    s0 = shift_cnt; v0 = valid_cnt;
    push = 1'b1; step(); push = 1'b0;
`ifdef LEITOR_SKIP_SAME_FLOOR_EN
    step(4);
    check("t6_skip_pulse", 32'(shift_cnt - s0), 1);
    check("t6_never_valid", 32'(valid_cnt - v0), 0);
    check("t6_occ0", 32'(occupancy), 0);
`else
    step(2);
    check("t6_valid", 32'(stop_valid), 1);
    check("t6_andar", 32'(stop_andar), 1);
    check("t6_noshift", 32'(shift_cnt - s0), 0);
    stop_ready = 1'b1; step(); stop_ready = 1'b0;
    step(2);
    check("t6_pulse", 32'(shift_cnt - s0), 1);
    check("t6_occ0", 32'(occupancy), 0);
`endif

    // Reset wins over push and flush in the same cycle
    reset = 1'b1; push = 1'b1; flush = 1'b1; step();
    reset = 1'b0; push = 1'b0; flush = 1'b0;
    check("rst_prio_occ", 32'(occupancy), 0);
    check("rst_prio_clear", 32'(ram_clear), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
